icache_assoc: RTL and testbench
===============================

Name: icache_assoc

Overview:
N-way set-associative instruction cache for the RV32I core, sitting between the Instruction Unit and the memory controller. It generalises the direct-mapped cache in three ways: way count and set count are parametrised, the cache owns its own refill state machine with a request/response handshake to memory, and it supports a whole-cache flush for fence.i. Hits respond one cycle after acceptance. Misses issue one block refill, install the block, then respond.

Parameters:
ADDR_WIDTH, 17, byte address width.
BLOCK_WIDTH, 4, log2 of block size in bytes; must be >= 3; BLOCK_SIZE = 2**BLOCK_WIDTH.
SET_WIDTH, 6, log2 of set count; TAG_WIDTH = ADDR_WIDTH-BLOCK_WIDTH-SET_WIDTH.
WAY_COUNT, 2, associativity; legal values are 1, 2 and 4.

Ports:
clkIn  in  1  system clock
resetNIn  in  1  asynchronous, active-low reset
flushIn  in  1  invalidate all lines (fence.i)
instrReqValid  in  1  fetch request valid
instrReqReady  out  1  cache can accept a request this cycle
instrAddrIn  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
instrRespValid  out  1  one-cycle pulse: instrOut and instrAddrOut are valid
instrOut  out  32  fetched instruction word
instrAddrOut  out  ADDR_WIDTH  address of the returned word
memReqValid  out  1  refill request
memReqReady  in  1  memory controller accepts the request
memReqAddr  out  ADDR_WIDTH-BLOCK_WIDTH  block address to refill
memRespValid  in  1  refill data valid, one cycle
memDataIn  in  BLOCK_SIZE*8  refill block data
missCountOut  out  32  accepted misses, wraps modulo 2^32

Behaviour:
- Reset (resetNIn=0, asynchronous):
  - all valid bits 0, replacement pointers 0, state IDLE;
  - instrRespValid, memReqValid and missCountOut are 0; instrOut, instrAddrOut and memReqAddr are 0.
  - Tag and data arrays are not reset.
- Address split: tag = addr[ADDR_WIDTH-1:BLOCK_WIDTH+SET_WIDTH]; set = addr[BLOCK_WIDTH+SET_WIDTH-1:BLOCK_WIDTH]; word = addr[BLOCK_WIDTH-1:2].
- Word k of a block is memDataIn[32k+31:32k], little-endian.
- instrReqReady = (state==IDLE) && !flushIn. A request is accepted when instrReqValid && instrReqReady.
- IDLE:
  - Accepted hit (any way valid with matching tag): at the next edge, register the word and address and pulse instrRespValid for 1 cycle. Stay in IDLE. Back-to-back hits give one response per cycle.
  - Accepted miss: latch the address, set memReqAddr = addr[ADDR_WIDTH-1:BLOCK_WIDTH], increment missCountOut, go to REQ.
  - flushIn=1: clear all valid bits and pointers at the next edge. No request is accepted that cycle.
- REQ: memReqValid=1, with memReqAddr held stable. When memReqReady=1, go to WAIT; memReqValid drops the next cycle.
- WAIT: when memRespValid=1:
  - write memDataIn and the tag into the victim way;
  - set its valid bit, unless a flush is pending;
  - at the next edge, pulse instrRespValid with the requested word (taken from memDataIn, not re-read from the array) and the latched address;
  - return to IDLE.
- Victim selection: the lowest-index invalid way in the set; if all ways are valid, the way at the set's round-robin pointer. The pointer advances modulo WAY_COUNT on every fill into a full set. With WAY_COUNT=1 the victim is always way 0.
- flushIn during REQ or WAIT:
  - records a pending flush;
  - the refill completes and the response is still delivered, but the filled line is left invalid;
  - all valid bits and pointers are cleared on the fill edge.
- memRespValid outside WAIT is ignored. memReqReady outside REQ is ignored.
- No response backpressure: the consumer must take instrRespValid when it is asserted.
- Asynchronous reset mid-refill abandons the refill: memReqValid drops immediately and no response is produced.

Test Plan:
- Cold miss: after reset, request 0x00104 with memReqReady=1; memRespValid 3 cycles later with block words {A0,A1,A2,A3} → memReqAddr=0x0010, a single memReqValid, instrRespValid with instrOut=A1, missCountOut=1. Then request 0x0010C → response A3 one cycle later and no memReqValid.
- 2-way conflict with SET_WIDTH=6, BLOCK_WIDTH=4: fill 0x00000, 0x00400 and 0x00800 (all set 0) → the third fill evicts way 0 (0x00000). Then 0x00400 hits, 0x00000 misses, and missCountOut=4.
- Delayed handshake: hold memReqReady=0 for 5 cycles → memReqValid and memReqAddr stay stable and instrReqReady=0 throughout. The response arrives 1 cycle after memRespValid.
- Flush: fill 0x00020, pulse flushIn, re-request 0x00020 → miss. Also pulse flushIn during WAIT → the response is delivered, but the next access to that block misses.
- Stray and reset: assert memRespValid while in IDLE → no state change. Then assert resetNIn=0 during WAIT → memReqValid=0 asynchronously, missCountOut=0, and the following request misses.

Source files
------------

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with its own refill FSM and fence.i flush.
// Lookups are combinational so that an accepted hit answers on the following edge.
module icache_assoc #(
  parameter int ADDR_WIDTH  = 17,
  parameter int BLOCK_WIDTH = 4,
  parameter int SET_WIDTH   = 6,
  parameter int WAY_COUNT   = 2
) (
  input  logic                              clkIn,
  input  logic                              resetNIn,
  input  logic                              flushIn,
  input  logic                              instrReqValid,
  output logic                              instrReqReady,
  input  logic [ADDR_WIDTH-1:0]             instrAddrIn,
  output logic                              instrRespValid,
  output logic [31:0]                       instrOut,
  output logic [ADDR_WIDTH-1:0]             instrAddrOut,
  output logic                              memReqValid,
  input  logic                              memReqReady,
  output logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] memReqAddr,
  input  logic                              memRespValid,
  input  logic [(2**BLOCK_WIDTH)*8-1:0]     memDataIn,
  output logic [31:0]                       missCountOut
);
  localparam int TAG_WIDTH  = ADDR_WIDTH - BLOCK_WIDTH - SET_WIDTH;
  localparam int SET_COUNT  = 2**SET_WIDTH;
  localparam int LINE_BITS  = (2**BLOCK_WIDTH) * 8;
  localparam int WORD_WIDTH = BLOCK_WIDTH - 2;
  localparam int WAY_BITS   = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} stateT;

  stateT                   stateReg;
  logic                    flushPendReg;
  logic [ADDR_WIDTH-1:0]   missAddrReg;
  logic [WAY_COUNT-1:0]    validReg [SET_COUNT];
  logic [WAY_BITS-1:0]     ptrReg   [SET_COUNT];

  logic [TAG_WIDTH-1:0]    reqTag, fillTag;
  logic [SET_WIDTH-1:0]    reqSet, fillSet;
  logic [WORD_WIDTH-1:0]   reqWord, fillWord;
  logic [WAY_COUNT-1:0]    wayHit;
  logic [WAY_COUNT-1:0][LINE_BITS-1:0] wayLine;
  logic                    hitAny;
  logic [LINE_BITS-1:0]    hitLine;
  logic [31:0]             hitWord, fillWordData;
  logic [WAY_BITS-1:0]     victimIdx, ptrNext;
  logic [WAY_COUNT-1:0]    victimSel;
  logic                    fillSetFull, fillEn;

  assign reqTag   = instrAddrIn[ADDR_WIDTH-1:BLOCK_WIDTH+SET_WIDTH];
  assign reqSet   = instrAddrIn[BLOCK_WIDTH+SET_WIDTH-1:BLOCK_WIDTH];
  assign reqWord  = instrAddrIn[BLOCK_WIDTH-1:2];
  assign fillTag  = missAddrReg[ADDR_WIDTH-1:BLOCK_WIDTH+SET_WIDTH];
  assign fillSet  = missAddrReg[BLOCK_WIDTH+SET_WIDTH-1:BLOCK_WIDTH];
  assign fillWord = missAddrReg[BLOCK_WIDTH-1:2];

  assign instrReqReady = (stateReg == IDLE) && !flushIn;
  assign fillEn        = (stateReg == WAIT) && memRespValid;

  // Tag and data storage per way; never reset, validity lives in validReg.
  generate
    for (genvar gi = 0; gi < WAY_COUNT; gi++) begin : gWay
      logic [TAG_WIDTH-1:0] tagMem  [SET_COUNT];
      logic [LINE_BITS-1:0] dataMem [SET_COUNT];

      always_ff @(posedge clkIn) begin
        if (fillEn && victimSel[gi]) begin
          tagMem[fillSet]  <= fillTag;
          dataMem[fillSet] <= memDataIn;
        end
      end

      assign wayHit[gi]  = validReg[reqSet][gi] && (tagMem[reqSet] == reqTag);
      assign wayLine[gi] = dataMem[reqSet];
    end
  endgenerate

  always_comb begin
    hitAny  = |wayHit;
    hitLine = '0;
    for (int w = 0; w < WAY_COUNT; w++) begin
      if (wayHit[w]) hitLine = hitLine | wayLine[w];
    end
  end

  assign hitWord      = hitLine[{reqWord, 5'b0} +: 32];
  assign fillWordData = memDataIn[{fillWord, 5'b0} +: 32];

  // Lowest-index invalid way wins; a full set falls back to its round-robin pointer.
  always_comb begin
    victimIdx   = ptrReg[fillSet];
    fillSetFull = &validReg[fillSet];
    for (int w = WAY_COUNT - 1; w >= 0; w--) begin
      if (!validReg[fillSet][w]) victimIdx = WAY_BITS'(w);
    end
    victimSel = '0;
    for (int w = 0; w < WAY_COUNT; w++) begin
      victimSel[w] = (victimIdx == WAY_BITS'(w));
    end
    ptrNext = (ptrReg[fillSet] == WAY_BITS'(WAY_COUNT - 1)) ? '0 : ptrReg[fillSet] + 1'b1;
  end

  always_ff @(posedge clkIn or negedge resetNIn) begin
    if (!resetNIn) begin
      stateReg       <= IDLE;
      flushPendReg   <= 1'b0;
      missAddrReg    <= '0;
      instrRespValid <= 1'b0;
      instrOut       <= '0;
      instrAddrOut   <= '0;
      memReqValid    <= 1'b0;
      memReqAddr     <= '0;
      missCountOut   <= '0;
      for (int s = 0; s < SET_COUNT; s++) begin
        validReg[s] <= '0;
        ptrReg[s]   <= '0;
      end
    end else begin
      instrRespValid <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (flushIn) begin
            for (int s = 0; s < SET_COUNT; s++) begin
              validReg[s] <= '0;
              ptrReg[s]   <= '0;
            end
          end else if (instrReqValid) begin
            if (hitAny) begin
              instrRespValid <= 1'b1;
              instrOut       <= hitWord;
              instrAddrOut   <= instrAddrIn;
            end else begin
              missAddrReg  <= instrAddrIn;
              memReqAddr   <= instrAddrIn[ADDR_WIDTH-1:BLOCK_WIDTH];
              memReqValid  <= 1'b1;
              missCountOut <= missCountOut + 32'd1;
              stateReg     <= REQ;
            end
          end
        end
        REQ: begin
          if (flushIn) flushPendReg <= 1'b1;
          if (memReqReady) begin
            memReqValid <= 1'b0;
            stateReg    <= WAIT;
          end
        end
        WAIT: begin
          if (memRespValid) begin
            // A flush seen during the refill wins: the fresh line is not marked valid.
            if (flushPendReg || flushIn) begin
              for (int s = 0; s < SET_COUNT; s++) begin
                validReg[s] <= '0;
                ptrReg[s]   <= '0;
              end
            end else begin
              validReg[fillSet] <= validReg[fillSet] | victimSel;
              if (fillSetFull) ptrReg[fillSet] <= ptrNext;
            end
            flushPendReg   <= 1'b0;
            instrRespValid <= 1'b1;
            instrOut       <= fillWordData;
            instrAddrOut   <= missAddrReg;
            stateReg       <= IDLE;
          end else if (flushIn) begin
            flushPendReg <= 1'b1;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc: directed scenarios plus randomized accesses
// compared against a set/way reference model and a fixed memory-content function.
module tb_icache_assoc;
  logic         clkIn = 1'b0;
  logic         resetNIn;
  logic         flushIn;
  logic         instrReqValid;
  logic         instrReqReady;
  logic [16:0]  instrAddrIn;
  logic         instrRespValid;
  logic [31:0]  instrOut;
  logic [16:0]  instrAddrOut;
  logic         memReqValid;
  logic         memReqReady;
  logic [12:0]  memReqAddr;
  logic         memRespValid;
  logic [127:0] memDataIn;
  logic [31:0]  missCountOut;

  int checks = 0;
  int errors = 0;

  // Reference model: per set, two ways of {valid, tag} and a round-robin pointer.
  bit          mValid [64][2];
  logic [6:0]  mTag   [64][2];
  int          mPtr   [64];
  logic [31:0] expMiss;

  icache_assoc dut (
    .clkIn(clkIn), .resetNIn(resetNIn), .flushIn(flushIn),
    .instrReqValid(instrReqValid), .instrReqReady(instrReqReady), .instrAddrIn(instrAddrIn),
    .instrRespValid(instrRespValid), .instrOut(instrOut), .instrAddrOut(instrAddrOut),
    .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqAddr(memReqAddr),
    .memRespValid(memRespValid), .memDataIn(memDataIn), .missCountOut(missCountOut)
  );

  always #5 clkIn = ~clkIn;

  function automatic logic [127:0] blockData(input logic [12:0] blk);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) begin
      d[32*k +: 32] = ({19'd0, blk} * 32'h9E3779B1) ^ (32'(k + 1) * 32'h01000193) ^ 32'hA5A50000;
    end
    return d;
  endfunction

  function automatic logic [31:0] wordOf(input logic [16:0] a);
    logic [127:0] d;
    int idx;
    d   = blockData(a[16:4]);
    idx = int'(a[3:2]);
    return d[32*idx +: 32];
  endfunction

  function automatic void modelClear();
    for (int s = 0; s < 64; s++) begin
      mValid[s][0] = 0;
      mValid[s][1] = 0;
      mPtr[s]      = 0;
    end
  endfunction

  function automatic void modelInstall(input logic [16:0] a);
    int s;
    int way;
    s   = int'(a[9:4]);
    way = -1;
    for (int w = 0; w < 2; w++) if (!mValid[s][w] && way < 0) way = w;
    if (way < 0) begin
      way     = mPtr[s];
      mPtr[s] = (mPtr[s] + 1) % 2;
    end
    mValid[s][way] = 1;
    mTag[s][way]   = a[16:10];
  endfunction

  // flushMode: 0 none, 1 flush on the REQ handshake cycle, 2 flush in WAIT (respDelay >= 1).
  task automatic doAccess(input logic [16:0] addr, input int readyDelay, input int respDelay,
                          input int flushMode);
    bit          hit;
    int          s;
    logic [31:0] expWord;
    s   = int'(addr[9:4]);
    hit = 0;
    for (int w = 0; w < 2; w++) if (mValid[s][w] && mTag[s][w] == addr[16:10]) hit = 1;
    expWord = wordOf(addr);

    @(negedge clkIn);
    checks++;
    if (instrRespValid !== 1'b0 || instrReqReady !== 1'b1) begin
      errors++;
      $display("FAIL idle_state addr=%h: got resp=%b ready=%b, expected resp=0 ready=1",
               addr, instrRespValid, instrReqReady);
    end
    instrReqValid = 1'b1;
    instrAddrIn   = addr;
    @(negedge clkIn);
    instrReqValid = 1'b0;

    if (hit) begin
      checks++;
      if (instrRespValid !== 1'b1 || instrOut !== expWord || instrAddrOut !== addr || memReqValid !== 1'b0) begin
        errors++;
        $display("FAIL hit_resp addr=%h: got v=%b data=%h a=%h mreq=%b, expected v=1 data=%h a=%h mreq=0",
                 addr, instrRespValid, instrOut, instrAddrOut, memReqValid, expWord, addr);
      end
    end else begin
      expMiss++;
      checks++;
      if (memReqValid !== 1'b1 || memReqAddr !== addr[16:4] || missCountOut !== expMiss ||
          instrReqReady !== 1'b0 || instrRespValid !== 1'b0) begin
        errors++;
        $display("FAIL miss_req addr=%h: got mreq=%b maddr=%h cnt=%0d rdy=%b resp=%b, expected 1 %h %0d 0 0",
                 addr, memReqValid, memReqAddr, missCountOut, instrReqReady, instrRespValid, addr[16:4], expMiss);
      end
      for (int i = 0; i < readyDelay; i++) begin
        @(negedge clkIn);
        checks++;
        if (memReqValid !== 1'b1 || memReqAddr !== addr[16:4] || instrReqReady !== 1'b0) begin
          errors++;
          $display("FAIL req_hold addr=%h cyc=%0d: got mreq=%b maddr=%h rdy=%b, expected 1 %h 0",
                   addr, i, memReqValid, memReqAddr, instrReqReady, addr[16:4]);
        end
      end
      memReqReady = 1'b1;
      if (flushMode == 1) flushIn = 1'b1;
      @(negedge clkIn);
      memReqReady = 1'b0;
      flushIn     = 1'b0;
      checks++;
      if (memReqValid !== 1'b0 || instrRespValid !== 1'b0) begin
        errors++;
        $display("FAIL req_drop addr=%h: got mreq=%b resp=%b, expected 0 0", addr, memReqValid, instrRespValid);
      end
      for (int i = 0; i < respDelay; i++) begin
        if (flushMode == 2 && i == 0) flushIn = 1'b1;
        @(negedge clkIn);
        flushIn = 1'b0;
        checks++;
        if (instrRespValid !== 1'b0 || instrReqReady !== 1'b0 || memReqValid !== 1'b0) begin
          errors++;
          $display("FAIL wait_quiet addr=%h cyc=%0d: got resp=%b rdy=%b mreq=%b, expected 0 0 0",
                   addr, i, instrRespValid, instrReqReady, memReqValid);
        end
      end
      memRespValid = 1'b1;
      memDataIn    = blockData(addr[16:4]);
      @(negedge clkIn);
      memRespValid = 1'b0;
      memDataIn    = {$urandom, $urandom, $urandom, $urandom};
      checks++;
      if (instrRespValid !== 1'b1 || instrOut !== expWord || instrAddrOut !== addr) begin
        errors++;
        $display("FAIL fill_resp addr=%h: got v=%b data=%h a=%h, expected v=1 data=%h a=%h",
                 addr, instrRespValid, instrOut, instrAddrOut, expWord, addr);
      end
      if (flushMode != 0) modelClear();
      else modelInstall(addr);
    end
    $display("access addr=%h %s word=%h flush=%0d misses=%0d", addr, hit ? "hit " : "miss", expWord,
             flushMode, expMiss);
  endtask

  task automatic test_reset();
    resetNIn      = 1'b0;
    flushIn       = 1'b0;
    instrReqValid = 1'b0;
    instrAddrIn   = '0;
    memReqReady   = 1'b0;
    memRespValid  = 1'b0;
    memDataIn     = '0;
    modelClear();
    expMiss = '0;
    repeat (2) @(negedge clkIn);
    checks++;
    if (instrRespValid !== 1'b0 || memReqValid !== 1'b0 || missCountOut !== 32'd0 ||
        instrOut !== 32'd0 || instrAddrOut !== 17'd0 || memReqAddr !== 13'd0 || instrReqReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got resp=%b mreq=%b cnt=%0d out=%h aout=%h maddr=%h rdy=%b, expected 0 0 0 0 0 0 1",
               instrRespValid, memReqValid, missCountOut, instrOut, instrAddrOut, memReqAddr, instrReqReady);
    end
    resetNIn = 1'b1;
    $display("reset released");
  endtask

  task automatic test_cold_miss();
    doAccess(17'h00104, 0, 2, 0);
    doAccess(17'h0010C, 0, 0, 0);
  endtask

  task automatic test_conflict();
    doAccess(17'h00000, 0, 1, 0);
    doAccess(17'h00400, 1, 0, 0);
    doAccess(17'h00800, 0, 2, 0);
    doAccess(17'h00400, 0, 0, 0);
    doAccess(17'h00000, 0, 1, 0);
  endtask

  task automatic test_delayed_handshake();
    doAccess(17'h01234, 5, 1, 0);
  endtask

  task automatic test_back_to_back();
    logic [16:0] base;
    logic [16:0] prev;
    base = 17'h00200;
    doAccess(base, 0, 0, 0);
    @(negedge clkIn);
    instrReqValid = 1'b1;
    instrAddrIn   = base;
    for (int k = 1; k <= 4; k++) begin
      prev = instrAddrIn;
      @(negedge clkIn);
      if (k < 4) instrAddrIn = base + 17'(4 * k);
      else instrReqValid = 1'b0;
      checks++;
      if (instrRespValid !== 1'b1 || instrOut !== wordOf(prev) || instrAddrOut !== prev || memReqValid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_hit addr=%h: got v=%b data=%h a=%h mreq=%b, expected v=1 data=%h a=%h mreq=0",
                 prev, instrRespValid, instrOut, instrAddrOut, memReqValid, wordOf(prev), prev);
      end
      $display("b2b addr=%h word=%h", prev, wordOf(prev));
    end
  endtask

  task automatic test_flush();
    doAccess(17'h00020, 0, 1, 0);
    @(negedge clkIn);
    flushIn       = 1'b1;
    instrReqValid = 1'b1;
    instrAddrIn   = 17'h00020;
    #1;
    checks++;
    if (instrReqReady !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got rdy=%b, expected 0", instrReqReady);
    end
    @(negedge clkIn);
    flushIn       = 1'b0;
    instrReqValid = 1'b0;
    checks++;
    if (instrRespValid !== 1'b0 || memReqValid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_accept: got resp=%b mreq=%b, expected 0 0", instrRespValid, memReqValid);
    end
    modelClear();
    $display("flush in idle");
    doAccess(17'h00020, 0, 0, 0);
    doAccess(17'h00030, 0, 2, 2);
    doAccess(17'h00030, 0, 0, 0);
    doAccess(17'h00044, 1, 0, 1);
    doAccess(17'h00044, 0, 1, 0);
  endtask

  task automatic test_stray_and_reset();
    logic [16:0] a;
    a = 17'h00C50;
    doAccess(a, 0, 0, 0);
    @(negedge clkIn);
    memRespValid = 1'b1;
    memReqReady  = 1'b1;
    memDataIn    = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clkIn);
    memRespValid = 1'b0;
    memReqReady  = 1'b0;
    checks++;
    if (instrRespValid !== 1'b0 || memReqValid !== 1'b0 || missCountOut !== expMiss || instrReqReady !== 1'b1) begin
      errors++;
      $display("FAIL stray_idle: got resp=%b mreq=%b cnt=%0d rdy=%b, expected 0 0 %0d 1",
               instrRespValid, memReqValid, missCountOut, instrReqReady, expMiss);
    end
    $display("stray memory strobes in idle");
    doAccess(a, 0, 0, 0);

    // Reset while a request is outstanding.
    @(negedge clkIn);
    instrReqValid = 1'b1;
    instrAddrIn   = 17'h0F000;
    @(negedge clkIn);
    instrReqValid = 1'b0;
    resetNIn      = 1'b0;
    #1;
    checks++;
    if (memReqValid !== 1'b0 || missCountOut !== 32'd0) begin
      errors++;
      $display("FAIL reset_req: got mreq=%b cnt=%0d, expected 0 0", memReqValid, missCountOut);
    end
    @(negedge clkIn);
    resetNIn = 1'b1;
    modelClear();
    expMiss = '0;
    $display("reset during REQ");

    // Reset while waiting for refill data.
    doAccess(a, 0, 0, 0);
    @(negedge clkIn);
    instrReqValid = 1'b1;
    instrAddrIn   = 17'h0F000;
    @(negedge clkIn);
    instrReqValid = 1'b0;
    memReqReady   = 1'b1;
    @(negedge clkIn);
    memReqReady = 1'b0;
    resetNIn    = 1'b0;
    #1;
    checks++;
    if (memReqValid !== 1'b0 || missCountOut !== 32'd0 || instrRespValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait: got mreq=%b cnt=%0d resp=%b, expected 0 0 0", memReqValid, missCountOut, instrRespValid);
    end
    @(negedge clkIn);
    resetNIn     = 1'b1;
    memRespValid = 1'b1;
    memDataIn    = blockData(13'h0F00);
    @(negedge clkIn);
    memRespValid = 1'b0;
    checks++;
    if (instrRespValid !== 1'b0 || memReqValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_resp: got resp=%b mreq=%b, expected 0 0", instrRespValid, memReqValid);
    end
    modelClear();
    expMiss = '0;
    $display("reset during WAIT");
    doAccess(17'h0F000, 0, 0, 0);
    doAccess(a, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [16:0] a;
    int rd;
    int rsp;
    int fm;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clkIn);
        flushIn = 1'b1;
        @(negedge clkIn);
        flushIn = 1'b0;
        modelClear();
        checks++;
        if (instrRespValid !== 1'b0 || memReqValid !== 1'b0) begin
          errors++;
          $display("FAIL rand_flush: got resp=%b mreq=%b, expected 0 0", instrRespValid, memReqValid);
        end
        $display("random idle flush");
      end else begin
        a   = {7'($urandom_range(0, 3)), 6'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 2'b00};
        rd  = $urandom_range(0, 3);
        rsp = $urandom_range(0, 3);
        fm  = 0;
        if ($urandom_range(0, 9) == 0) fm = (rsp > 0) ? int'($urandom_range(1, 2)) : 1;
        doAccess(a, rd, rsp, fm);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_delayed_handshake();
    test_back_to_back();
    test_flush();
    test_stray_and_reset();
    test_random();
    @(negedge clkIn);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
